// File: rtl/pim_cmp_pkg.sv
// Shared types for the bit-serial signed comparator: FSM state encoding and default operand width.
package pim_cmp_pkg;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/gt_int_serial_if.sv
// Operand/result handshake bundle for gt_int_serial; EQ exists only when GT_SERIAL_EQ_EN is defined.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1; valid,
// once raised, holds its payload stable until that edge; ready may change freely.
interface gt_int_serial_if
  import pim_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic             Y;
`ifdef GT_SERIAL_EQ_EN
  logic             EQ;
`endif

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y
`ifdef GT_SERIAL_EQ_EN
    , input EQ
`endif
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y
`ifdef GT_SERIAL_EQ_EN
    , output EQ
`endif
  );
endinterface

// File: rtl/subtractor_1bit_cmp.sv
// One bit of the B - A borrow chain: computes the borrow out of b_i - a_i - borrow_in.
module subtractor_1bit_cmp (
  input  logic b_i,
  input  logic a_i,
  input  logic borrow_in,
  output logic borrow_out
);
  assign borrow_out = (~b_i & a_i) | (~(b_i ^ a_i) & borrow_in);
endmodule

// File: rtl/gt_int_serial.sv
// Bit-serial signed A > B comparator: evaluates B - A LSB-first, one bit per clock, WIDTH cycles per op.
// Optional EQ output and its difference-seen flag are built when GT_SERIAL_EQ_EN is defined.
module gt_int_serial
  import pim_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  gt_int_serial_if.slave bus,
  output state_t        dbg_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             borrow, borrow_nxt;
  logic             y_r;
  logic             in_ready_c, out_valid_c;
`ifdef GT_SERIAL_EQ_EN
  logic             diff_seen;
`endif

  subtractor_1bit_cmp u_sub (
    .b_i       (b_sr[0]),
    .a_i       (a_sr[0]),
    .borrow_in (borrow),
    .borrow_out(borrow_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_n = BUSY;
      end
      BUSY: if (cnt == LAST) state_n = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands shift right so bit i always sits at position 0 on step i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      y_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sr   <= bus.A;
          b_sr   <= bus.B;
          cnt    <= '0;
          borrow <= 1'b0;
          y_r    <= 1'b0;
        end
        BUSY: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= borrow_nxt;
          if (cnt == LAST) begin
            // Differing sign bits decide directly; equal signs fall back to the unsigned borrow.
            y_r <= (a_sr[0] != b_sr[0]) ? b_sr[0] : borrow_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GT_SERIAL_EQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           diff_seen <= 1'b0;
    else if (state == IDLE && bus.in_valid) diff_seen <= 1'b0;
    else if (state == BUSY)               diff_seen <= diff_seen | (a_sr[0] ^ b_sr[0]);
  end

  assign bus.EQ = (state == DONE) & ~diff_seen;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.Y         = y_r;
  assign dbg_state     = state;
endmodule

// File: tb/tb_gt_int_serial.sv
// Directed bench for gt_int_serial: latency, signed compare corners, backpressure, reset abort, back-to-back.
module tb_gt_int_serial;
  import pim_cmp_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks;
  int     errors;

  gt_int_serial_if #(.WIDTH(16)) bus ();

  gt_int_serial #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the result handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input logic exp_y, input logic exp_eq);
    int lat;
    check({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom_range(0, 16'hffff));
    bus.B = 16'($urandom_range(0, 16'hffff));
    check({tag, "_in_ready_busy"}, bus.in_ready, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 16'(lat), 16'd16);
    check({tag, "_y"}, bus.Y, exp_y);
`ifdef GT_SERIAL_EQ_EN
    check({tag, "_eq"}, bus.EQ, exp_eq);
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 16'($urandom_range(0, 16'hffff));
      step();
      check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      check({tag, "_hold_y"}, bus.Y, exp_y);
      check({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_state_idle"}, 16'(dbg_state), 16'(IDLE));
    check({tag, "_in_ready_back"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid_drop"}, bus.out_valid, 1'b0);
    if (exp_eq) begin end
  endtask

  logic [15:0] b2b_a [4] = '{16'h0003, 16'hfffe, 16'h7fff, 16'h0000};
  logic [15:0] b2b_b [4] = '{16'h0005, 16'hfffd, 16'h7ffe, 16'h0001};
  logic        b2b_y [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [0:0]  exp_q [$];

  initial begin
    int idx, got, saw_valid;
    logic prev_ready, prev_valid, ready_due;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_y", bus.Y, 1'b0);
    check("rst_state", 16'(dbg_state), 16'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op("pos_gt", 16'h0005, 16'h0003, 0, 1'b1, 1'b0);
    run_op("neg1_vs_0", 16'hffff, 16'h0000, 0, 1'b0, 1'b0);
    run_op("max_vs_min", 16'h7fff, 16'h8000, 0, 1'b1, 1'b0);
    run_op("min_vs_max", 16'h8000, 16'h7fff, 0, 1'b0, 1'b0);
    run_op("min_vs_neg1", 16'h8000, 16'hffff, 0, 1'b0, 1'b0);
    run_op("equal", 16'h1234, 16'h1234, 0, 1'b0, 1'b1);
    run_op("lt_by_one", 16'h1234, 16'h1235, 0, 1'b0, 1'b0);
    run_op("zero_eq", 16'h0000, 16'h0000, 0, 1'b0, 1'b1);
    run_op("backpressure", 16'h0010, 16'h000f, 5, 1'b1, 1'b0);

    // Abort mid-operation: this op would have produced Y=1.
    bus.A = 16'h0100;
    bus.B = 16'h0001;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_y", bus.Y, 1'b0);
    check("abort_state", 16'(dbg_state), 16'(IDLE));
`ifdef GT_SERIAL_EQ_EN
    check("abort_eq", bus.EQ, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 0;
    repeat (20) begin
      step();
      if (bus.out_valid) saw_valid++;
    end
    check("abort_no_result", 16'(saw_valid), 16'd0);
    run_op("after_abort", 16'h0002, 16'h0007, 0, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    idx = 0;
    got = 0;
    prev_ready = 1'b0;
    prev_valid = 1'b0;
    ready_due = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 200 && got < 4; c++) begin
      if (ready_due) check("b2b_ready_after_hs", bus.in_ready, 1'b1);
      ready_due = 1'b0;
      if (prev_ready && prev_valid) check("b2b_ready_pulse", bus.in_ready, 1'b0);
      if (bus.in_ready) begin
        if (idx < 4) begin
          bus.A = b2b_a[idx];
          bus.B = b2b_b[idx];
          exp_q.push_back(b2b_y[idx]);
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_result", 16'd1, 16'd0);
        end else begin
          check("b2b_y", bus.Y, exp_q.pop_front());
        end
        got++;
        ready_due = 1'b1;
      end
      prev_ready = bus.in_ready;
      prev_valid = bus.in_valid;
      step();
    end
    if (ready_due) check("b2b_ready_after_last", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_results", 16'(got), 16'd4);
    check("b2b_issued", 16'(idx), 16'd4);
    check("b2b_queue_empty", 16'(exp_q.size()), 16'd0);
    repeat (3) step();
    check("b2b_no_extra", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gt_int_serial.md
GT_INT_SERIAL -- requirements
Module: gt_int_serial

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be at least 2.
REQ-002 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port: in_valid, input, 1, operand pair A/B offered.
REQ-005 Port: in_ready, output, 1, block can accept an operand pair.
REQ-006 Port: A, input, WIDTH, signed two's-complement operand, sampled on accept.
REQ-007 Port: B, input, WIDTH, signed two's-complement operand, sampled on accept.
REQ-008 Port: out_valid, output, 1, result available.
REQ-009 Port: out_ready, input, 1, consumer takes the result.
REQ-010 Port: Y, output, 1, 1 when A > B (signed), valid while out_valid=1.
REQ-011 Port: EQ, output, 1, 1 when A == B; present only with GT_SERIAL_EQ_EN.

Function
REQ-012 The block SHALL compute signed A > B bit-serially as unsigned B−A, LSB-first, one bit per cycle, through a registered borrow.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 IDLE: in_ready=1; on in_valid=1, the block SHALL latch A and B into shift registers, clear borrow and bit counter, and move to BUSY.
REQ-015 BUSY: in_ready=0; each cycle the block SHALL consume bit i of both operands, update the borrow, increment the counter, and move to DONE after bit WIDTH−1.
REQ-016 The result SHALL be computed at the MSB step.
  - Y = b_msb when a_msb != b_msb.
  - Y = final unsigned borrow of B−A when the sign bits are equal.
REQ-017 DONE: out_valid=1, with Y (and EQ) held stable until out_ready=1.
REQ-018 On out_valid=1 and out_ready=1, the block SHALL return to IDLE; in_ready SHALL rise the next cycle, with no same-cycle re-accept.
REQ-019 Latency: out_valid SHALL assert exactly WIDTH cycles after the accept edge.
REQ-020 in_valid and input changes outside IDLE SHALL be ignored.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within one operation.

Reset
REQ-022 When rst_n=0, the block SHALL immediately force the following, regardless of state, including mid-BUSY:
  - state to IDLE;
  - in_ready=1, out_valid=0, Y=0, EQ=0;
  - counter, borrow and shift registers to 0.
REQ-023 An operation aborted by reset SHALL produce no result.

Configuration
REQ-024 Macro GT_SERIAL_EQ_EN, when defined, SHALL add:
  - output EQ;
  - a sticky "difference seen" flag, set on any bit where a_i != b_i;
  - EQ = NOT flag in DONE.
REQ-025 When GT_SERIAL_EQ_EN is undefined, the EQ port and its flag SHALL be absent, and Y timing SHALL be unchanged.

Structure
REQ-026 Package pim_cmp_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the default WIDTH constant.
REQ-027 The per-bit borrow logic SHALL be one instance of sub-module subtractor_1bit_cmp, with inputs b_i, a_i, borrow_in and output borrow_out.

Verification
REQ-028 The bench SHALL cover the following scenarios:
  - A=5, B=3, out_ready=1 -> out_valid exactly 16 cycles after accept, Y=1.
  - A=0xFFFF (−1), B=0x0000 -> Y=0; A=0x7FFF, B=0x8000 -> Y=1.
  - A=B=0x1234 with GT_SERIAL_EQ_EN -> Y=0, EQ=1; A=0x1234, B=0x1235 -> Y=0, EQ=0.
  - A=0x0010, B=0x000F, out_ready held 0 for 5 cycles -> Y=1 and out_valid stay stable; in_ready=0 throughout; IDLE one cycle after handshake.
  - rst_n pulsed low at BUSY cycle 8 -> outputs at reset values immediately; next op A=2, B=7 -> Y=0 after 16 cycles.
  - Back-to-back ops with in_valid held 1 -> in_ready pulses exactly one cycle after each result handshake; no operand pair lost or doubled.
